// File: rtl/pc_pkg.sv
// Shared types and defaults for the PC fetch unit.
//   pc_state_e     : sequencer states BOOT / RUN / HALTED
//   XLEN_DEFAULT   : default PC / address width
//   RESET_VEC_*    : default PC loaded on reset
//   TRAP_VEC_*     : default PC loaded on a trapped misaligned redirect
//   PC_INCR        : sequential fetch stride in bytes
package pc_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'h0000_0100;
  localparam int unsigned PC_INCR           = 4;
  localparam int unsigned CNT_W             = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: redirect > stall > fire > hold, plus misaligned
// redirect handling.
// Configuration macro: PC_MISALIGN_TRAP_EN
//   defined   : misaligned redirect loads TRAP_VEC and raises misalign_next
//   undefined : target bits [1:0] are cleared, misalign_next is 0
// Ports:
//   pc, pc_plus4     : current PC and its sequential successor
//   redirect, target : redirect request and destination
//   stall, fire      : hold request and accepted-fetch indication
//   next_pc          : PC to load at the next edge
//   misalign_next    : trapped-misalign pulse to register
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT)
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  input  logic            fire,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign_next
);

  // Priority selection; stall outranks fire so an accepted fetch under stall
  // is counted by the top but the PC does not move.
  always_comb begin
    next_pc       = pc;
    misalign_next = 1'b0;
    if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        next_pc       = TRAP_VEC;
        misalign_next = 1'b1;
      end else begin
        next_pc = redirect_target;
      end
`else
      next_pc = {redirect_target[XLEN-1:2], 2'b00};
`endif
    end else if (stall) begin
      next_pc = pc;
    end else if (fire) begin
      next_pc = pc_plus4;
    end
  end

`ifndef PC_MISALIGN_TRAP_EN
  // Low target bits and the trap vector have no effect in this build.
  logic unused_misalign_inputs;
  assign unused_misalign_inputs = ^{TRAP_VEC, redirect_target[1:0]};
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter register and fetch-request sequencer.
// Configuration macro: PC_MISALIGN_TRAP_EN (misaligned-redirect trap).
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   stall_i             : hold PC in RUN
//   redirect_i          : load redirect_target_i at the next edge
//   redirect_target_i   : redirect destination
//   halt_i, resume_i    : enter / leave HALTED
//   fetch_ready_i       : instruction memory accepts the request
//   fetch_valid_o       : fetch request valid (RUN only)
//   pc_o                : current PC / fetch address
//   pc_plus4_o          : combinational pc_o + 4
//   fetch_count_o       : accepted fetch count (wraps)
//   misalign_o          : one-cycle pulse after a trapped misaligned redirect
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_target_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic             misalign_o
);

  pc_state_e       state;
  logic            fire;
  logic [XLEN-1:0] next_pc;
  logic            misalign_next;

  assign fire       = fetch_valid_o & fetch_ready_i;
  assign pc_plus4_o = pc_o + XLEN'(PC_INCR);

  pc_next_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .pc              (pc_o),
    .pc_plus4        (pc_plus4_o),
    .redirect        (redirect_i),
    .redirect_target (redirect_target_i),
    .stall           (stall_i),
    .fire            (fire),
    .next_pc         (next_pc),
    .misalign_next   (misalign_next)
  );

  // Sequencer, PC, counter and pulse registers. fetch_valid_o is registered
  // alongside the state so it is high exactly while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc_o          <= RESET_VEC;
      fetch_valid_o <= 1'b0;
      fetch_count_o <= '0;
      misalign_o    <= 1'b0;
    end else begin
      pc_o       <= next_pc;
      misalign_o <= misalign_next;
      if (fire) begin
        fetch_count_o <= fetch_count_o + CNT_W'(1);
      end
      case (state)
        BOOT: begin
          state         <= halt_i ? HALTED : RUN;
          fetch_valid_o <= ~halt_i;
        end
        RUN: begin
          state         <= halt_i ? HALTED : RUN;
          fetch_valid_o <= ~halt_i;
        end
        HALTED: begin
          // halt_i wins over a simultaneous resume_i
          if (resume_i && !halt_i) begin
            state         <= RUN;
            fetch_valid_o <= 1'b1;
          end else begin
            fetch_valid_o <= 1'b0;
          end
        end
        default: begin
          state         <= BOOT;
          fetch_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by a
// randomized run compared against a cycle-level behavioural model.
module tb_pc_fetch_unit;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk;
  logic        rst_n;
  logic        stall, redirect, halt, resume, ready;
  logic [31:0] tgt;
  logic        valid, mis;
  logic [31:0] pc, pc4, cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [31:0] m_pc, m_cnt;
  bit          m_valid, m_mis;
  int          m_mode;

  pc_fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall),
    .redirect_i        (redirect),
    .redirect_target_i (tgt),
    .halt_i            (halt),
    .resume_i          (resume),
    .fetch_ready_i     (ready),
    .fetch_valid_o     (valid),
    .pc_o              (pc),
    .pc_plus4_o        (pc4),
    .fetch_count_o     (cnt),
    .misalign_o        (mis)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    stall = 0; redirect = 0; halt = 0; resume = 0; ready = 0; tgt = '0;
  endtask

  // One clock edge of the specified behaviour, from the inputs now applied.
  task automatic model_step();
    bit f;
    f = m_valid && ready;
    if (f) m_cnt = m_cnt + 1;
    m_mis = 0;
    if (redirect) begin
      if (TRAP_EN && tgt[1:0] != 2'b00) begin
        m_pc  = TRAP_PC;
        m_mis = 1;
      end else begin
        m_pc = tgt & 32'hFFFF_FFFC;
      end
    end else if (f && !stall) begin
      m_pc = m_pc + 4;
    end
    if (m_mode == M_HALT) m_mode = (resume && !halt) ? M_RUN : M_HALT;
    else                  m_mode = halt ? M_HALT : M_RUN;
    m_valid = (m_mode == M_RUN);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    m_pc = RESET_PC; m_cnt = 0; m_valid = 0; m_mis = 0; m_mode = M_BOOT;
  endtask

  task automatic test_reset();
    idle_inputs();
    ready = 1;
    @(posedge clk); #1;
    apply_reset();
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_checks++; if (cnt !== 32'h0) begin n_errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    n_checks++; if (mis !== 1'b0) begin n_errors++; $display("FAIL reset_mis got %b exp 0", mis); end
    n_checks++; if (pc4 !== 32'h4) begin n_errors++; $display("FAIL reset_pc4 got %h exp 4", pc4); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL boot_valid got %b exp 0", valid); end
    cycle();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h0) begin n_errors++; $display("FAIL run_entry got valid=%b pc=%h exp valid=1 pc=0", valid, pc); end
    n_checks++; if (cnt !== 32'd0) begin n_errors++; $display("FAIL boot_nocount got %0d exp 0", cnt); end
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_checks++; if (pc !== 32'(i * 4)) begin n_errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, 32'(i * 4)); end
      n_checks++; if (cnt !== 32'(i)) begin n_errors++; $display("FAIL seq_cnt[%0d] got %0d exp %0d", i, cnt, i); end
    end
  endtask

  task automatic test_backpressure();
    cycle();
    n_checks++; if (pc !== 32'h10 || cnt !== 32'd4) begin n_errors++; $display("FAIL bp_start got pc=%h cnt=%0d exp pc=10 cnt=4", pc, cnt); end
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (pc !== 32'h10 || cnt !== 32'd4 || valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold[%0d] got pc=%h cnt=%0d valid=%b exp pc=10 cnt=4 valid=1", i, pc, cnt, valid); end
    end
    ready = 1;
    cycle();
    n_checks++; if (pc !== 32'h14 || cnt !== 32'd5) begin n_errors++; $display("FAIL bp_release got pc=%h cnt=%0d exp pc=14 cnt=5", pc, cnt); end
  endtask

  task automatic test_redirect_stall();
    ready = 0; stall = 1; redirect = 1; tgt = 32'h200;
    cycle();
    redirect = 0;
    n_checks++; if (pc !== 32'h200 || cnt !== 32'd5) begin n_errors++; $display("FAIL redir_stall got pc=%h cnt=%0d exp pc=200 cnt=5", pc, cnt); end
    ready = 1;
    cycle();
    n_checks++; if (pc !== 32'h200 || cnt !== 32'd6) begin n_errors++; $display("FAIL stall_fire got pc=%h cnt=%0d exp pc=200 cnt=6", pc, cnt); end
    stall = 0;
    cycle();
    n_checks++; if (pc !== 32'h204 || cnt !== 32'd7) begin n_errors++; $display("FAIL unstall got pc=%h cnt=%0d exp pc=204 cnt=7", pc, cnt); end
  endtask

  task automatic test_wrap();
    ready = 0; redirect = 1; tgt = 32'hFFFF_FFFC;
    cycle();
    redirect = 0;
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_load got %h exp fffffffc", pc); end
    n_checks++; if (pc4 !== 32'h0) begin n_errors++; $display("FAIL wrap_pc4 got %h exp 0", pc4); end
    ready = 1;
    cycle();
    n_checks++; if (pc !== 32'h0 || cnt !== 32'd8) begin n_errors++; $display("FAIL wrap_adv got pc=%h cnt=%0d exp pc=0 cnt=8", pc, cnt); end
  endtask

  task automatic test_halt_redirect();
    ready = 1; halt = 1; redirect = 1; tgt = 32'h40;
    cycle();
    halt = 0; redirect = 0;
    n_checks++; if (pc !== 32'h40 || valid !== 1'b0 || cnt !== 32'd9) begin n_errors++; $display("FAIL halt_redir got pc=%h valid=%b cnt=%0d exp pc=40 valid=0 cnt=9", pc, valid, cnt); end
    stall = 1;
    cycle();
    n_checks++; if (pc !== 32'h40 || valid !== 1'b0) begin n_errors++; $display("FAIL halted_hold got pc=%h valid=%b exp pc=40 valid=0", pc, valid); end
    halt = 1; resume = 1;
    cycle();
    n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL halt_and_resume got valid=%b exp 0", valid); end
    halt = 0; stall = 0;
    cycle();
    resume = 0;
    n_checks++; if (pc !== 32'h40 || valid !== 1'b1 || cnt !== 32'd9) begin n_errors++; $display("FAIL resume got pc=%h valid=%b cnt=%0d exp pc=40 valid=1 cnt=9", pc, valid, cnt); end
    cycle();
    n_checks++; if (pc !== 32'h44 || cnt !== 32'd10) begin n_errors++; $display("FAIL post_resume got pc=%h cnt=%0d exp pc=44 cnt=10", pc, cnt); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    ready = 0; redirect = 1; tgt = 32'h102;
    cycle();
    redirect = 0;
    n_checks++; if (pc !== 32'h100 || mis !== TRAP_EN) begin n_errors++; $display("FAIL mis_102 got pc=%h mis=%b exp pc=100 mis=%b", pc, mis, TRAP_EN); end
    cycle();
    n_checks++; if (pc !== 32'h100 || mis !== 1'b0) begin n_errors++; $display("FAIL mis_pulse_end got pc=%h mis=%b exp pc=100 mis=0", pc, mis); end
    redirect = 1; tgt = 32'h203;
    cycle();
    redirect = 0;
    exp_pc = TRAP_EN ? TRAP_PC : 32'h200;
    n_checks++; if (pc !== exp_pc || mis !== TRAP_EN) begin n_errors++; $display("FAIL mis_203 got pc=%h mis=%b exp pc=%h mis=%b", pc, mis, exp_pc, TRAP_EN); end
    cycle();
    n_checks++; if (mis !== 1'b0) begin n_errors++; $display("FAIL mis_203_end got %b exp 0", mis); end
  endtask

  task automatic test_boot_halt();
    ready = 0;
    @(negedge clk);
    apply_reset();
    n_checks++; if (pc !== 32'h0 || valid !== 1'b0 || cnt !== 32'h0) begin n_errors++; $display("FAIL midop_reset got pc=%h valid=%b cnt=%0d exp pc=0 valid=0 cnt=0", pc, valid, cnt); end
    halt = 1; redirect = 1; tgt = 32'h300;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // first edge after release: BOOT -> HALTED with redirect honoured
    m_pc = 32'h300; m_mode = M_HALT; m_valid = 0;
    halt = 0; tgt = 32'h400;
    n_checks++; if (pc !== 32'h300 || valid !== 1'b0) begin n_errors++; $display("FAIL boot_halt got pc=%h valid=%b exp pc=300 valid=0", pc, valid); end
    cycle();
    redirect = 0;
    n_checks++; if (pc !== 32'h400 || valid !== 1'b0) begin n_errors++; $display("FAIL halted_redir got pc=%h valid=%b exp pc=400 valid=0", pc, valid); end
    resume = 1;
    cycle();
    resume = 0;
    n_checks++; if (pc !== 32'h400 || valid !== 1'b1) begin n_errors++; $display("FAIL boot_resume got pc=%h valid=%b exp pc=400 valid=1", pc, valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      stall    = ($urandom % 4) == 0;
      redirect = ($urandom % 6) == 0;
      halt     = ($urandom % 12) == 0;
      resume   = ($urandom % 3) == 0;
      ready    = ($urandom % 3) != 0;
      tgt      = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      cycle();
      n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rand_pc[%0d] got %h exp %h", i, pc, m_pc); end
      n_checks++; if (pc4 !== m_pc + 32'd4) begin n_errors++; $display("FAIL rand_pc4[%0d] got %h exp %h", i, pc4, m_pc + 32'd4); end
      n_checks++; if (valid !== m_valid) begin n_errors++; $display("FAIL rand_valid[%0d] got %b exp %b", i, valid, m_valid); end
      n_checks++; if (cnt !== m_cnt) begin n_errors++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", i, cnt, m_cnt); end
      n_checks++; if (mis !== m_mis) begin n_errors++; $display("FAIL rand_mis[%0d] got %b exp %b", i, mis, m_mis); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_backpressure();
    test_redirect_stall();
    test_wrap();
    test_halt_redirect();
    test_misalign();
    test_boot_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
